// File: rtl/sgen_nco_sweep_ctrl.sv
// Stepped linear chirp sequencer driving the sgen_nco FCW and enable.
// Define SGEN_NCO_SWEEP_BIDIR_EN for a triangle (up then down) sweep.
module sgen_nco_sweep_ctrl #(
  parameter int gp_phase_accu_width = 16,
  parameter int gp_dwell_width      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_an,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [gp_phase_accu_width-1:0] i_fcw_start,
  input  logic [gp_phase_accu_width-1:0] i_fcw_stop,
  input  logic [gp_phase_accu_width-1:0] i_fcw_step,
  input  logic [gp_dwell_width-1:0]      i_dwell,
  output logic [gp_phase_accu_width-1:0] o_fcw,
  output logic                           o_nco_ena,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_dir
);

  localparam int W = gp_phase_accu_width;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0] fcw_q, fcw_d;
  logic [W-1:0] stop_q, stop_d;
  logic [W-1:0] step_q, step_d;
  logic [gp_dwell_width-1:0] dwell_q, dwell_d;
  logic [gp_dwell_width-1:0] cnt_q, cnt_d;
  logic ena_q, ena_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fin;

  logic [W:0]   up_sum;
  logic [W-1:0] up_next;
  logic         up_last;

  // Extra bit catches wrap; the step clamps to stop on carry.
  assign up_sum  = {1'b0, fcw_q} + {1'b0, step_q};
  assign up_next = (up_sum[W] || (up_sum[W-1:0] >= stop_q)) ?
                   stop_q : up_sum[W-1:0];
  assign up_last = (fcw_q >= stop_q) || (step_q == '0);

`ifdef SGEN_NCO_SWEEP_BIDIR_EN
  logic [W-1:0] start_q, start_d;
  logic         dir_q, dir_d;
  logic         degen_q, degen_d;
  logic [W:0]   dn_diff;
  logic [W-1:0] dn_next;
  logic         dn_last;

  assign dn_diff = {1'b0, fcw_q} - {1'b0, step_q};
  assign dn_next = (dn_diff[W] || (dn_diff[W-1:0] <= start_q)) ?
                   start_q : dn_diff[W-1:0];
  assign dn_last = (fcw_q <= start_q);
  assign o_dir   = dir_q;
`else
  assign o_dir = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    fcw_d   = fcw_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    ena_d   = ena_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fin     = 1'b0;
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
    start_d = start_q;
    dir_d   = dir_q;
    degen_d = degen_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_abort) begin
          fcw_d = '0;
        end else if (i_start) begin
          state_d = DWELL;
          fcw_d   = i_fcw_start;
          stop_d  = i_fcw_stop;
          step_d  = i_fcw_step;
          dwell_d = i_dwell;
          cnt_d   = i_dwell;
          ena_d   = 1'b1;
          busy_d  = 1'b1;
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
          start_d = i_fcw_start;
          dir_d   = 1'b0;
          degen_d = (i_fcw_step == '0) ||
                    (i_fcw_start >= i_fcw_stop);
`endif
        end
      end
      DWELL: begin
        if (i_abort) begin
          state_d = IDLE;
          fcw_d   = '0;
          ena_d   = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
          dir_d   = 1'b0;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = dwell_q;
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
          if (dir_q) begin
            if (dn_last) fin = 1'b1;
            else         fcw_d = dn_next;
          end else if (up_last) begin
            if (degen_q) begin
              fin = 1'b1;
            end else begin
              dir_d = 1'b1;
              fcw_d = dn_next;
            end
          end else begin
            fcw_d = up_next;
          end
`else
          if (up_last) fin = 1'b1;
          else         fcw_d = up_next;
`endif
        end
        if (fin) begin
          state_d = DONE;
          ena_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
          dir_d   = 1'b0;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        if (i_abort) fcw_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state_q <= IDLE;
      fcw_q   <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
      start_q <= '0;
      dir_q   <= 1'b0;
      degen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
      start_q <= start_d;
      dir_q   <= dir_d;
      degen_q <= degen_d;
`endif
    end
  end

  assign o_fcw     = fcw_q;
  assign o_nco_ena = ena_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_sgen_nco_sweep_ctrl.sv
// Scoreboard bench for sgen_nco_sweep_ctrl: directed sweeps,
// clamping, degenerate sweeps, abort and async reset.
module tb_sgen_nco_sweep_ctrl;

  localparam int W  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_an = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  fs = '0;
  logic [W-1:0]  fe = '0;
  logic [W-1:0]  st = '0;
  logic [DW-1:0] dw = '0;
  logic [W-1:0]  o_fcw;
  logic          o_nco_ena;
  logic          o_busy;
  logic          o_done;
  logic          o_dir;

  sgen_nco_sweep_ctrl #(
    .gp_phase_accu_width(W),
    .gp_dwell_width(DW)
  ) dut (
    .i_clk(clk),
    .i_rst_an(rst_an),
    .i_start(start),
    .i_abort(abort),
    .i_fcw_start(fs),
    .i_fcw_stop(fe),
    .i_fcw_step(st),
    .i_dwell(dw),
    .o_fcw(o_fcw),
    .o_nco_ena(o_nco_ena),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_dir(o_dir)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] fcw;
    logic         ena;
    logic         busy;
    logic         done;
    logic         dir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_act;
  exp_t mon_exp;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic push_hold(input logic [W-1:0] f, input int n,
                           input logic d);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{fcw: f, ena: 1'b1, busy: 1'b1,
                        done: 1'b0, dir: d});
  endtask

  task automatic push_done(input logic [W-1:0] f);
    exp_q.push_back('{fcw: f, ena: 1'b0, busy: 1'b0,
                      done: 1'b1, dir: 1'b0});
  endtask

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Monitor: every presented output pops one expected entry.
  always @(negedge clk) begin
    if (rst_an && (o_nco_ena || o_done)) begin
      mon_act = '{fcw: o_fcw, ena: o_nco_ena, busy: o_busy,
                  done: o_done, dir: o_dir};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_out: got fcw=%0d ena=%b busy=%b done=%b dir=%b, expected no output",
                 o_fcw, o_nco_ena, o_busy, o_done, o_dir);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_miss++;
          $display("FAIL sweep_out: got fcw=%0d ena=%b busy=%b done=%b dir=%b, expected fcw=%0d ena=%b busy=%b done=%b dir=%b",
                   mon_act.fcw, mon_act.ena, mon_act.busy,
                   mon_act.done, mon_act.dir, mon_exp.fcw,
                   mon_exp.ena, mon_exp.busy, mon_exp.done,
                   mon_exp.dir);
        end
      end
    end
  end

  task automatic start_sweep(input logic [W-1:0] a,
                             input logic [W-1:0] b,
                             input logic [W-1:0] c,
                             input logic [DW-1:0] d);
    @(negedge clk);
    fs = a; fe = b; st = c; dw = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {o_fcw, o_nco_ena, o_busy, o_done, o_dir}, 0);
    rst_an = 1'b1;
    repeat (2) @(negedge clk);

    // 1: four steps, three cycles each
    push_hold(16'd100, 3, 1'b0);
    push_hold(16'd200, 3, 1'b0);
    push_hold(16'd300, 3, 1'b0);
    push_hold(16'd400, 3, 1'b0);
    push_done(16'd400);
    start_sweep(16'd100, 16'd400, 16'd100, 16'd0002);
    drain("s1_drain");

    // 2: clamp to stop; stray start and config change ignored
    push_hold(16'd100, 1, 1'b0);
    push_hold(16'd200, 1, 1'b0);
    push_hold(16'd300, 1, 1'b0);
    push_hold(16'd350, 1, 1'b0);
    push_done(16'd350);
    start_sweep(16'd100, 16'd350, 16'd100, 16'd0);
    fs = 16'd7; fe = 16'd9; dw = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("s2_drain");

    // 3: carry at top of range clamps
    push_hold(16'hFF00, 1, 1'b0);
    push_hold(16'hFF80, 1, 1'b0);
    push_hold(16'hFFFF, 1, 1'b0);
    push_done(16'hFFFF);
    start_sweep(16'hFF00, 16'hFFFF, 16'h0080, 16'd0);
    drain("s3_drain");

    // 5: start >= stop, then step = 0
    push_hold(16'd500, 2, 1'b0);
    push_done(16'd500);
    start_sweep(16'd500, 16'd200, 16'd10, 16'd1);
    drain("s5a_drain");
    push_hold(16'd100, 2, 1'b0);
    push_done(16'd100);
    start_sweep(16'd100, 16'd400, 16'd0, 16'd1);
    drain("s5b_drain");

    // 6: direction behaviour
`ifdef SGEN_NCO_SWEEP_BIDIR_EN
    push_hold(16'd100, 1, 1'b0);
    push_hold(16'd200, 1, 1'b0);
    push_hold(16'd300, 1, 1'b0);
    push_hold(16'd200, 1, 1'b1);
    push_hold(16'd100, 1, 1'b1);
    push_done(16'd100);
`else
    push_hold(16'd100, 1, 1'b0);
    push_hold(16'd200, 1, 1'b0);
    push_hold(16'd300, 1, 1'b0);
    push_done(16'd300);
`endif
    start_sweep(16'd100, 16'd300, 16'd100, 16'd0);
    drain("s6_drain");

    // 4a: abort in second step with simultaneous start
    push_hold(16'd100, 3, 1'b0);
    push_hold(16'd200, 1, 1'b0);
    start_sweep(16'd100, 16'd400, 16'd100, 16'd2);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outs", {o_fcw, o_nco_ena, o_busy, o_done, o_dir}, 0);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_idle", {o_fcw, o_nco_ena, o_busy, o_done}, 0);
    drain("s4a_drain");

    // 4b: async reset mid-sweep
    push_hold(16'd100, 1, 1'b0);
    start_sweep(16'd100, 16'd400, 16'd100, 16'd2);
    @(posedge clk);
    #2;
    rst_an = 1'b0;
    #1;
    chk("async_rst", {o_fcw, o_nco_ena, o_busy, o_done, o_dir}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_an = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {o_fcw, o_nco_ena, o_busy, o_done}, 0);
    drain("s4b_drain");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
